// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - dual-write, dual-read register file with sequential clear
// Entry 0 reads as zero; the clear walk initialises every entry (SP gets SP_INIT).
module reg_file_mp #(
  parameter int unsigned          XLEN    = 32,
  parameter int unsigned          NREGS   = 32,
  parameter int unsigned          AW      = $clog2(NREGS),
  parameter int unsigned          SP_IDX  = 2,
  parameter logic [XLEN-1:0]      SP_INIT = 'h1000,
  parameter bit                   BYPASS  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            busy,
  input  logic            we0,
  input  logic [AW-1:0]   waddr0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            we1,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata1,
  input  logic [AW-1:0]   raddr0,
  output logic [XLEN-1:0] rdata0,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q;
  logic [AW-1:0]     clr_cnt_q;
  logic [AW-1:0]     clr_cnt_d;
  logic              busy_q;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic [XLEN-1:0]   clr_val_d;
  logic              wr0_d;
  logic              wr1_d;

  always_comb begin
    clr_cnt_d = clr_cnt_q + 1'b1;
    clr_val_d = (clr_cnt_q == AW'(SP_IDX)) ? SP_INIT : '0;
    // Port 1 wins an address collision, so port 0 is suppressed outright.
    wr1_d     = we1 && (waddr1 != '0);
    wr0_d     = we0 && (waddr0 != '0) && !(we1 && (waddr1 == waddr0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          mem_q[clr_cnt_q] <= clr_val_d;
          clr_cnt_q        <= clr_cnt_d;
          if (clr_cnt_q == AW'(NREGS - 1)) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (wr0_d) mem_q[waddr0] <= wdata0;
          if (wr1_d) mem_q[waddr1] <= wdata1;
        end
        default: begin
          state_q <= CLEAR;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy = busy_q;

  always_comb begin
    rdata0 = '0;
    if (state_q == RUN && raddr0 != '0) begin
      if (BYPASS && we1 && waddr1 == raddr0)      rdata0 = wdata1;
      else if (BYPASS && we0 && waddr0 == raddr0) rdata0 = wdata0;
      else                                        rdata0 = mem_q[raddr0];
    end
  end

  always_comb begin
    rdata1 = '0;
    if (state_q == RUN && raddr1 != '0) begin
      if (BYPASS && we1 && waddr1 == raddr1)      rdata1 = wdata1;
      else if (BYPASS && we0 && waddr0 == raddr1) rdata1 = wdata0;
      else                                        rdata1 = mem_q[raddr1];
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed bench for reg_file_mp
// Drives one bypassing and one non-bypassing instance with shared inputs.
module tb_reg_file_mp;

  logic        clk;
  logic        reset;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1, raddr0, raddr1;
  logic [31:0] wdata0, wdata1;
  logic        busy_b, busy_n;
  logic [31:0] rdata0_b, rdata1_b, rdata0_n, rdata1_n;

  int n_vec = 0;
  int n_err = 0;

  reg_file_mp #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .busy(busy_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr0(raddr0), .rdata0(rdata0_b),
    .raddr1(raddr1), .rdata1(rdata1_b)
  );

  reg_file_mp #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .reset(reset), .busy(busy_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr0(raddr0), .rdata0(rdata0_n),
    .raddr1(raddr1), .rdata1(rdata1_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic test_reset;
    int cnt;
    reset = 1; raddr0 = 5'd2; raddr1 = 5'd2;
    tick;
    n_vec++; if (busy_b !== 1'b1) begin n_err++; $display("FAIL reset_busy got=%b exp=1", busy_b); end
    n_vec++; if (rdata0_b !== 32'h0) begin n_err++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0_b); end
    n_vec++; if (rdata1_n !== 32'h0) begin n_err++; $display("FAIL reset_rdata1_n got=%h exp=0", rdata1_n); end
    tick;
    reset = 0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      cnt++;
      if (!busy_b) break;
      n_vec++; if (rdata0_b !== 32'h0) begin n_err++; $display("FAIL clear_rdata0 cyc=%0d got=%h exp=0", cnt, rdata0_b); end
    end
    n_vec++; if (cnt !== 32) begin n_err++; $display("FAIL clear_len got=%0d exp=32", cnt); end
    n_vec++; if (busy_n !== 1'b0) begin n_err++; $display("FAIL clear_busy_n got=%b exp=0", busy_n); end
    for (int i = 0; i < 32; i++) begin
      raddr0 = 5'(i); raddr1 = 5'(i);
      #1;
      n_vec++;
      if (rdata0_b !== ((i == 2) ? 32'h1000 : 32'h0)) begin
        n_err++; $display("FAIL clear_val_b x%0d got=%h exp=%h", i, rdata0_b, (i == 2) ? 32'h1000 : 32'h0);
      end
      n_vec++;
      if (rdata1_n !== ((i == 2) ? 32'h1000 : 32'h0)) begin
        n_err++; $display("FAIL clear_val_n x%0d got=%h exp=%h", i, rdata1_n, (i == 2) ? 32'h1000 : 32'h0);
      end
    end
  endtask

  task automatic test_dual_write;
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'hAAAA0000;
    we1 = 1; waddr1 = 5'd5; wdata1 = 32'h5555FFFF;
    raddr0 = 5'd5;
    #1;
    n_vec++; if (rdata0_b !== 32'h5555FFFF) begin n_err++; $display("FAIL conflict_bypass got=%h exp=5555ffff", rdata0_b); end
    tick;
    idle_inputs;
    #1;
    n_vec++; if (rdata0_b !== 32'h5555FFFF) begin n_err++; $display("FAIL conflict_b got=%h exp=5555ffff", rdata0_b); end
    n_vec++; if (rdata0_n !== 32'h5555FFFF) begin n_err++; $display("FAIL conflict_n got=%h exp=5555ffff", rdata0_n); end
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'h11;
    we1 = 1; waddr1 = 5'd4; wdata1 = 32'h22;
    tick;
    idle_inputs;
    raddr0 = 5'd3; raddr1 = 5'd4;
    #1;
    n_vec++; if (rdata0_n !== 32'h11) begin n_err++; $display("FAIL disjoint_x3 got=%h exp=11", rdata0_n); end
    n_vec++; if (rdata1_n !== 32'h22) begin n_err++; $display("FAIL disjoint_x4 got=%h exp=22", rdata1_n); end
  endtask

  task automatic test_zero_reg;
    we0 = 1; waddr0 = 5'd0; wdata0 = 32'hDEADBEEF; raddr0 = 5'd0;
    #1;
    n_vec++; if (rdata0_b !== 32'h0) begin n_err++; $display("FAIL zero_same_b got=%h exp=0", rdata0_b); end
    tick;
    idle_inputs;
    #1;
    n_vec++; if (rdata0_b !== 32'h0) begin n_err++; $display("FAIL zero_next_b got=%h exp=0", rdata0_b); end
    n_vec++; if (rdata0_n !== 32'h0) begin n_err++; $display("FAIL zero_next_n got=%h exp=0", rdata0_n); end
  endtask

  task automatic test_bypass;
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'h1;
    tick;
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'h99; raddr1 = 5'd7;
    #1;
    n_vec++; if (rdata1_b !== 32'h99) begin n_err++; $display("FAIL bypass_b got=%h exp=99", rdata1_b); end
    n_vec++; if (rdata1_n !== 32'h1) begin n_err++; $display("FAIL nobypass_old got=%h exp=1", rdata1_n); end
    tick;
    idle_inputs;
    #1;
    n_vec++; if (rdata1_n !== 32'h99) begin n_err++; $display("FAIL nobypass_new got=%h exp=99", rdata1_n); end
    n_vec++; if (rdata1_b !== 32'h99) begin n_err++; $display("FAIL bypass_held got=%h exp=99", rdata1_b); end
  endtask

  task automatic test_back_to_back;
    for (int i = 10; i < 14; i++) begin
      we1 = 1; waddr1 = 5'(i); wdata1 = 32'h100 + 32'(i);
      tick;
    end
    idle_inputs;
    for (int i = 10; i < 14; i++) begin
      raddr0 = 5'(i);
      #1;
      n_vec++;
      if (rdata0_n !== 32'h100 + 32'(i)) begin
        n_err++; $display("FAIL b2b x%0d got=%h exp=%h", i, rdata0_n, 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_reset_mid_clear;
    int cnt;
    reset = 1;
    tick;
    reset = 0;
    repeat (10) tick;
    reset = 1;
    tick;
    n_vec++; if (busy_b !== 1'b1) begin n_err++; $display("FAIL midclr_busy got=%b exp=1", busy_b); end
    reset = 0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      cnt++;
      if (!busy_b) break;
    end
    n_vec++; if (cnt !== 32) begin n_err++; $display("FAIL midclr_len got=%0d exp=32", cnt); end
    raddr0 = 5'd2; raddr1 = 5'd13;
    #1;
    n_vec++; if (rdata0_b !== 32'h1000) begin n_err++; $display("FAIL midclr_sp got=%h exp=1000", rdata0_b); end
    n_vec++; if (rdata1_n !== 32'h0) begin n_err++; $display("FAIL midclr_x13 got=%h exp=0", rdata1_n); end
  endtask

  task automatic test_write_during_busy;
    int cnt;
    we0 = 1; waddr0 = 5'd9; wdata0 = 32'h5A;
    tick;
    idle_inputs;
    reset = 1;
    tick;
    reset = 0;
    raddr0 = 5'd9;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      we0 = (cnt == 19); waddr0 = 5'd9; wdata0 = 32'h77;
      tick;
      cnt++;
      if (!busy_b) break;
      n_vec++; if (rdata0_b !== 32'h0) begin n_err++; $display("FAIL busy_rd cyc=%0d got=%h exp=0", cnt, rdata0_b); end
    end
    idle_inputs;
    #1;
    n_vec++; if (cnt !== 32) begin n_err++; $display("FAIL busy_len got=%0d exp=32", cnt); end
    n_vec++; if (rdata0_b !== 32'h0) begin n_err++; $display("FAIL busy_wr_b got=%h exp=0", rdata0_b); end
    n_vec++; if (rdata0_n !== 32'h0) begin n_err++; $display("FAIL busy_wr_n got=%h exp=0", rdata0_n); end
  endtask

  initial begin
    idle_inputs;
    reset = 0; raddr0 = 0; raddr1 = 0;
    test_reset;
    test_dual_write;
    test_zero_reg;
    test_bypass;
    test_back_to_back;
    test_reset_mid_clear;
    test_write_during_busy;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the core's single-write register file: configurable width and depth, two write ports, two read ports.
- Optional write-to-read bypass for the pipelined decode stage.
- Sequential hardware clear after reset: every register is initialised, walking one entry per cycle.
- Sits between ID (reads) and WB (ALU/load write-back).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=4)
AW, $clog2(NREGS), address width (derived, not overridden)
SP_IDX, 2, index of the stack-pointer register
SP_INIT, 32'h1000, value loaded into SP_IDX by the clear sequence
BYPASS, 1, 1 = read ports see same-cycle writes; 0 = read old contents

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high; starts the clear sequence
busy  out  1  high while the clear sequence runs
we0  in  1  write enable, port 0 (ALU write-back)
waddr0  in  AW  write address, port 0
wdata0  in  XLEN  write data, port 0
we1  in  1  write enable, port 1 (load write-back)
waddr1  in  AW  write address, port 1
wdata1  in  XLEN  write data, port 1
raddr0  in  AW  read address, port 0
rdata0  out  XLEN  read data, port 0 (combinational)
raddr1  in  AW  read address, port 1
rdata1  out  XLEN  read data, port 1 (combinational)

Behaviour:
- Reset and the clock/reset convention are fixed: one clock `clk`; `reset` is synchronous and active-high.

- FSM states: CLEAR, RUN.
  - reset=1 at an edge: state <= CLEAR, clr_cnt <= 0, busy <= 1.
  - Reset in either state, including mid-clear, restarts the clear from index 0.

- CLEAR state:
  - Each cycle writes mem[clr_cnt] <= (clr_cnt==SP_IDX) ? SP_INIT : 0, then clr_cnt++.
  - When clr_cnt==NREGS-1 is written: state <= RUN, busy <= 0 on the same edge.
  - The clear takes exactly NREGS cycles after reset deasserts; busy rises on the reset edge.
  - During CLEAR:
    - we0 and we1 are ignored (no write).
    - rdata0 and rdata1 are forced to 0.
    - No bypass is applied.

- RUN state, writes:
  - we0 writes wdata0 to waddr0; we1 writes wdata1 to waddr1; both on the same edge.
  - Same address with both enabled: port 1 wins, and port 0's write is dropped.
  - A write to address 0 is discarded on either port. mem[0] stays 0 permanently.

- RUN state, reads (combinational):
  - raddr==0 returns 0, always.
  - If BYPASS=1, raddr!=0 and we1&&waddr1==raddr: return wdata1.
  - Otherwise, if BYPASS=1, raddr!=0 and we0&&waddr0==raddr: return wdata0.
  - Otherwise return mem[raddr].
  - If BYPASS=0, reads always return mem[raddr]; a written value becomes visible the cycle after the write edge.

- Widths: addresses are AW bits; no out-of-range addresses exist. Data is stored unmodified at XLEN bits.
- No X may propagate to rdata after busy falls; every entry has been written by the clear.
- Outputs at reset edge: busy=1, rdata0=rdata1=0.
- Storage must map to flops; no reset term on the data array beyond the clear walk.

Test Plan:
- Clear sequence: assert reset 2 cycles, release → busy=1 for exactly 32 cycles. After that, read x2 = 0x00001000 and x1..x31 (excluding x2) = 0.
- Reset mid-clear: reset at clear cycle 10 → busy remains 1 for a further full 32 cycles from release. x2 = 0x1000 at the end.
- Dual write conflict: we0=we1=1, waddr0=waddr1=5, wdata0=0xAAAA0000, wdata1=0x5555FFFF → next cycle x5 = 0x5555FFFF.
  - Also with ports disjoint: waddr0=3/0x11, waddr1=4/0x22 → x3=0x11, x4=0x22.
- Zero register: we0=1, waddr0=0, wdata0=0xDEADBEEF → rdata0 for raddr0=0 is 0 in the same and the following cycle.
- Bypass: BYPASS=1, x7 holds 0x1; same cycle we0=1, waddr0=7, wdata0=0x99, raddr1=7 → rdata1=0x99 immediately.
  - With BYPASS=0 instance, same stimulus → rdata1=0x1 that cycle, 0x99 the next.
- Writes during busy: we0=1, waddr0=9, wdata0=0x77 asserted during clear cycle 20 → after busy falls, x9=0. rdata0 reads 0 throughout busy.
